// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands the single UART transmit buffer to one byte-stream
// requester per message, pacing each byte as a baud-aligned strobe pulse.
module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int TIMEOUT_TICKS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              baud_x1,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [7:0]        buf_data,
    output logic              buf_strobe
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
    localparam logic [TW-1:0] TLAST   = (TIMEOUT_TICKS > 0) ? TW'(TIMEOUT_TICKS - 1) : '0;
    localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, OWN, HI, LO} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   rrPtr_q, rrPtr_d;
    logic [IW-1:0]   ownerIdx_q, ownerIdx_d;
    logic [TW-1:0]   timeCnt_q, timeCnt_d;
    logic            last_q, last_d;
    logic [7:0]      bufData_q, bufData_d;
    logic            bufStrobe_q, bufStrobe_d;

    logic            winValid;
    logic [IW-1:0]   winIdx;
    logic [IW-1:0]   candIdx;
    logic            accept;
    logic [7:0]      ownerByte;

    // Scan downward so the candidate closest after rrPtr_q is the last one to win.
    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        candIdx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            candIdx = IW'((32'(rrPtr_q) + 32'(k)) % 32'(NREQ));
            if (req_valid[candIdx]) begin
                winValid = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    assign ownerByte = req_data[{ownerIdx_q, 3'b000} +: 8];
    assign accept    = (state_q == OWN) && req_valid[ownerIdx_q];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rrPtr_d     = rrPtr_q;
        ownerIdx_d  = ownerIdx_q;
        timeCnt_d   = timeCnt_q;
        last_d      = last_q;
        bufData_d   = bufData_q;
        bufStrobe_d = bufStrobe_q;
        case (state_q)
            IDLE: begin
                if (winValid) begin
                    grant_d          = '0;
                    grant_d[winIdx]  = 1'b1;
                    ownerIdx_d       = winIdx;
                    timeCnt_d        = '0;
                    state_d          = OWN;
                end
            end
            OWN: begin
                // Acceptance takes precedence over a coincident tick.
                if (accept) begin
                    bufData_d   = ownerByte;
                    last_d      = req_last[ownerIdx_q];
                    bufStrobe_d = 1'b1;
                    state_d     = HI;
                end else if (baud_x1 && (TIMEOUT_TICKS != 0)) begin
                    if (timeCnt_q == TLAST) begin
                        grant_d   = '0;
                        rrPtr_d   = ownerIdx_q;
                        timeCnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        timeCnt_d = timeCnt_q + TW'(1);
                    end
                end
            end
            HI: begin
                if (baud_x1) begin
                    bufStrobe_d = 1'b0;
                    state_d     = LO;
                end
            end
            LO: begin
                if (baud_x1) begin
                    if (last_q) begin
                        grant_d = '0;
                        rrPtr_d = ownerIdx_q;
                        state_d = IDLE;
                    end else begin
                        timeCnt_d = '0;
                        state_d   = OWN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rrPtr_q     <= PTR_RST;
            ownerIdx_q  <= '0;
            timeCnt_q   <= '0;
            last_q      <= 1'b0;
            bufData_q   <= 8'h00;
            bufStrobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rrPtr_q     <= rrPtr_d;
            ownerIdx_q  <= ownerIdx_d;
            timeCnt_q   <= timeCnt_d;
            last_q      <= last_d;
            bufData_q   <= bufData_d;
            bufStrobe_q <= bufStrobe_d;
        end
    end

    assign req_ready  = grant_q & {NREQ{state_q == OWN}};
    assign grant      = grant_q;
    assign busy       = |grant_q;
    assign buf_data   = bufData_q;
    assign buf_strobe = bufStrobe_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requesters replay queued messages, a tick-sampled edge
// detector stands in for the UART buffer, and a round-robin model predicts the byte stream.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              baud_x1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [7:0]        buf_data;
    logic              buf_strobe;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_TICKS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_x1    (baud_x1),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .grant      (grant),
        .busy       (busy),
        .buf_data   (buf_data),
        .buf_strobe (buf_strobe)
    );

    always #5 clk = ~clk;

    logic [8:0]      laneMem [NREQ][128];
    int              head [NREQ];
    int              tail [NREQ];
    logic [7:0]      recvQ[$];
    logic [7:0]      expQ[$];
    logic [NREQ-1:0] grantSeq[$];
    logic [NREQ-1:0] expGrant[$];
    logic [NREQ-1:0] prevGrant;
    logic [NREQ-1:0] readyAtEdge;
    logic            bufPrev;
    int              strobeHighTicks;
    int              assertCount = 0;
    int              failCount   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: drive lanes from their queues, model the buffer's tick sampler, pop accepted bytes.
    task automatic applyStimulus(input bit tick);
        logic [NREQ-1:0] acc;
        @(negedge clk);
        baud_x1   = tick;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]       = 1'b1;
                req_last[i]        = laneMem[i][head[i]][8];
                req_data[8*i +: 8] = laneMem[i][head[i]][7:0];
            end
        end
        #1;
        readyAtEdge = req_ready;
        acc = req_valid & req_ready;
        if (tick) begin
            if (buf_strobe && !bufPrev) recvQ.push_back(buf_data);
            if (buf_strobe) strobeHighTicks++;
            bufPrev = buf_strobe;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (acc[i]) head[i]++;
        if (grant != '0 && prevGrant == '0) grantSeq.push_back(grant);
        prevGrant = grant;
        checkOutput("busy_vs_grant", 32'(busy), 32'(|grant));
        checkOutput("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        checkOutput("ready_only_owner", 32'(req_ready & ~grant), 32'd0);
    endtask

    task automatic clearTb();
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        recvQ.delete();
        expQ.delete();
        grantSeq.delete();
        expGrant.delete();
        prevGrant       = '0;
        bufPrev         = 1'b0;
        strobeHighTicks = 0;
    endtask

    task automatic resetDut();
        clearTb();
        reset = 1'b1;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        reset = 1'b0;
        clearTb();
    endtask

    task automatic loadByte(input int lane, input logic [7:0] b, input bit last);
        laneMem[lane][tail[lane]] = {last, b};
        tail[lane]++;
    endtask

    task automatic loadMsg(input int lane, input int len);
        for (int j = 0; j < len; j++) loadByte(lane, 8'($urandom), j == len - 1);
    endtask

    // Whole messages go out in round-robin order among lanes still holding messages.
    task automatic buildExpected();
        int h[NREQ];
        int ptr;
        int w;
        logic [8:0] b;
        expQ.delete();
        expGrant.delete();
        for (int i = 0; i < NREQ; i++) h[i] = head[i];
        ptr = NREQ - 1;
        forever begin
            w = -1;
            for (int k = NREQ; k >= 1; k--) if (h[(ptr + k) % NREQ] < tail[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
            if (w < 0) break;
            expGrant.push_back(NREQ'(1) << w);
            do begin
                b = laneMem[w][h[w]];
                h[w]++;
                expQ.push_back(b[7:0]);
            end while (!b[8]);
            ptr = w;
        end
    endtask

    task automatic runUntilDone(input int period, input int budget);
        bit done = 1'b0;
        bit empty;
        for (int n = 0; n < budget && !done; n++) begin
            applyStimulus((n % period) == period - 1);
            empty = 1'b1;
            for (int i = 0; i < NREQ; i++) if (head[i] < tail[i]) empty = 1'b0;
            done = empty && (grant == '0) && !buf_strobe;
        end
        checkOutput("run_completed", 32'(done), 32'd1);
    endtask

    task automatic compareStreams(input string tag);
        checkOutput({tag, "_byte_count"}, recvQ.size(), expQ.size());
        for (int i = 0; i < recvQ.size() && i < expQ.size(); i++)
            checkOutput({tag, "_byte"}, 32'(recvQ[i]), 32'(expQ[i]));
        checkOutput({tag, "_grant_count"}, grantSeq.size(), expGrant.size());
        for (int i = 0; i < grantSeq.size() && i < expGrant.size(); i++)
            checkOutput({tag, "_grant"}, 32'(grantSeq[i]), 32'(expGrant[i]));
    endtask

    initial begin
        int n;
        int ownTicks;
        reset     = 1'b0;
        baud_x1   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        clearTb();

        resetDut();
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_strobe", 32'(buf_strobe), 32'd0);
        checkOutput("rst_data", 32'(buf_data), 32'h00);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);

        // Single "OK\r\n" message from requester 1.
        loadByte(1, 8'h4F, 1'b0);
        loadByte(1, 8'h4B, 1'b0);
        loadByte(1, 8'h0D, 1'b0);
        loadByte(1, 8'h0A, 1'b1);
        buildExpected();
        applyStimulus(1'b0);
        checkOutput("single_grant", 32'(grant), 32'b0010);
        checkOutput("single_ready_same_cycle", 32'(req_ready), 32'b0010);
        applyStimulus(1'b0);
        checkOutput("single_strobe_rise", 32'(buf_strobe), 32'd1);
        checkOutput("single_first_byte", 32'(buf_data), 32'h4F);
        runUntilDone(8, 2000);
        compareStreams("single");
        checkOutput("single_high_ticks", strobeHighTicks, 4);
        checkOutput("single_release", 32'(grant), 32'd0);

        // Contention between requesters 0 and 2.
        resetDut();
        loadMsg(0, 3);
        loadMsg(2, 3);
        buildExpected();
        runUntilDone(4, 2000);
        compareStreams("contention");

        // Fairness among requesters 0, 1, 3 with single-byte messages.
        resetDut();
        for (int m = 0; m < 3; m++) begin
            loadMsg(0, 1);
            loadMsg(1, 1);
            loadMsg(3, 1);
        end
        buildExpected();
        runUntilDone(2, 2000);
        compareStreams("fairness");

        // Timeout: requester 2 stalls mid-message, requester 3 is waiting.
        resetDut();
        loadByte(2, 8'h21, 1'b0);
        loadByte(3, 8'h33, 1'b1);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            applyStimulus((n % 3) == 2);
            n++;
            if (head[2] == tail[2] && req_ready[2]) break;
        end
        checkOutput("to_back_in_own", 32'(req_ready), 32'b0100);
        ownTicks = 0;
        for (int c = 0; c < 200 && ownTicks < 4; c++) begin
            applyStimulus((n % 3) == 2);
            if (((n % 3) == 2) && readyAtEdge[2]) begin
                ownTicks++;
                if (ownTicks == 3) checkOutput("to_hold_after_3", 32'(grant), 32'b0100);
            end
            n++;
        end
        checkOutput("to_release_on_4th", 32'(grant), 32'd0);
        applyStimulus(1'b0);
        checkOutput("to_next_grant", 32'(grant), 32'b1000);
        runUntilDone(3, 500);
        checkOutput("to_byte_count", recvQ.size(), 2);
        if (recvQ.size() == 2) begin
            checkOutput("to_byte0", 32'(recvQ[0]), 32'h21);
            checkOutput("to_byte1", 32'(recvQ[1]), 32'h33);
        end

        // Ticks in both the acceptance cycle and the first HI cycle.
        resetDut();
        loadByte(1, 8'h55, 1'b1);
        applyStimulus(1'b0);
        checkOutput("tc_grant", 32'(grant), 32'b0010);
        applyStimulus(1'b1);
        checkOutput("tc_strobe_high", 32'(buf_strobe), 32'd1);
        checkOutput("tc_data", 32'(buf_data), 32'h55);
        applyStimulus(1'b1);
        checkOutput("tc_strobe_low", 32'(buf_strobe), 32'd0);
        checkOutput("tc_writes_once", recvQ.size(), 1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("tc_release", 32'(grant), 32'd0);
        checkOutput("tc_writes_total", recvQ.size(), 1);

        // Reset while the strobe is high.
        resetDut();
        loadByte(1, 8'h41, 1'b0);
        loadByte(1, 8'h42, 1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("rhi_in_hi", 32'(buf_strobe), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0);
        reset = 1'b0;
        checkOutput("rhi_grant", 32'(grant), 32'd0);
        checkOutput("rhi_busy", 32'(busy), 32'd0);
        checkOutput("rhi_strobe", 32'(buf_strobe), 32'd0);
        checkOutput("rhi_data", 32'(buf_data), 32'h00);
        checkOutput("rhi_ready", 32'(req_ready), 32'd0);
        clearTb();
        loadMsg(1, 3);
        buildExpected();
        runUntilDone(5, 1000);
        compareStreams("rhi_after");

        // Randomized message mixes at random baud rates.
        for (int r = 0; r < 4; r++) begin
            resetDut();
            for (int m = 0; m < int'($urandom_range(3, 8)); m++)
                loadMsg(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(1, 4)));
            buildExpected();
            runUntilDone(int'($urandom_range(1, 6)), 3000);
            compareStreams("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing the single UART transmit buffer (`uart_buffer` byte/strobe input) among NREQ byte-stream requesters (CPU debug port, BCD number formatter, status reporter, …). It grants the buffer to one requester for a whole message, terminated by `req_last`. It paces each byte as a strobe pulse aligned to `baud_x1` ticks, so the buffer's tick-sampled edge detector sees every byte exactly once. A per-grant idle timeout stops a stalled requester from locking out the others.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- TIMEOUT_TICKS, 16, `baud_x1` ticks an owner may idle before losing the grant; 0 disables the timeout

Ports:
- clk  in  1  system clock
- reset  in  1  reset reset, synchronous, active-high; clock clk
- baud_x1  in  1  one-clk tick at baud rate, same source as the buffer's `baud_x1`
- req_valid  in  NREQ  requester i has a byte on its data lane
- req_last  in  NREQ  byte on lane i is the last of its message
- req_data  in  8*NREQ  lane i at bits [8i+7:8i]
- req_ready  out  NREQ  byte on lane i is accepted this cycle when valid is also high
- grant  out  NREQ  one-hot current owner, all zero when free
- busy  out  1  any grant active
- buf_data  out  8  to `uart_buffer.data`
- buf_strobe  out  1  to `uart_buffer.data_strobe`

## Operation
- State machine: IDLE, OWN, HI, LO.
- IDLE:
  - If any `req_valid` is high, select the first valid requester scanning from `rr_ptr+1` upward, modulo NREQ.
  - Next cycle: `grant` is one-hot for the winner, state is OWN, timeout counter is 0.
  - No byte is accepted in IDLE.
- OWN:
  - `req_ready[i] = grant[i] & (state==OWN)`, combinational from registers.
  - On owner valid&ready: latch the lane byte into `buf_data`, latch `req_last` into `last_q`, set `buf_strobe<=1`, go to HI.
  - Otherwise, each `baud_x1` increments the timeout counter. When the counter reaches TIMEOUT_TICKS (nonzero): clear grant, set `rr_ptr<=owner`, go to IDLE.
  - Valid bytes from non-owners are ignored; their ready stays 0.
- HI: on `baud_x1`, set `buf_strobe<=0` and go to LO.
- LO, on `baud_x1`:
  - If `last_q`: clear grant, set `rr_ptr<=owner`, go to IDLE.
  - Else: go to OWN and clear the timeout counter.
- `buf_data` changes only on acceptance, so it is stable from strobe rise until after the buffer's registered strobe falls.
- `busy = |grant`.
- Round-robin fairness: a requester that has just finished or timed out has the lowest priority at the next arbitration.

## Timing
- Reset values: `grant=0`, `req_ready=0`, `busy=0`, `buf_strobe=0`, `buf_data=8'h00`, state IDLE, `rr_ptr=NREQ-1` (requester 0 wins first), timeout counter 0, `last_q=0`.
- Latency:
  - `req_valid` rise in IDLE to `grant`: 1 clk.
  - Grant to first possible accept: same cycle as OWN entry.
  - Accept to `buf_strobe=1`: 1 clk.
- A `baud_x1` in the same cycle as acceptance is not counted toward HI. HI waits for a tick that occurs while in state HI, which guarantees the buffer samples `buf_strobe=1` at least once.
- Strobe is high for exactly one HI-state tick interval, then low for one LO-state tick interval.
- Peak throughput: 1 byte per 2 `baud_x1` ticks. No byte is lost or duplicated at this pace.
- `baud_x1` coincident with acceptance in OWN: acceptance wins and the timeout counter is not incremented.
- After a message ends, a new grant can start 1 clk after the LO tick (via IDLE). A requester holding valid with multiple messages re-arbitrates against the others.
- Reset mid-HI/LO: all outputs return to reset values next cycle. The byte in flight may be written or dropped; the next message starts cleanly.
- NREQ=1 degenerates to pass-through pacing.
- Overflow of the 256-entry buffer is not detected; senders must bound message size or rate.

## Test plan
- Single message: requester 1 sends "OK\r\n" with last on `\n`; `baud_x1` every 8 clk. Expect grant=0010, 4 strobe pulses each high for one tick interval and low for one, buf_data 0x4F,0x4B,0x0D,0x0A in order, then grant=0.
- Contention: requesters 0 and 2 both valid from reset with 3-byte messages. Expect requester 0's full message, then requester 2's. Never interleaved.
- Fairness: requesters 0, 1, 3 continuously valid with 1-byte messages. Grants cycle 0→1→3→0…, with requester 0 first after reset.
- Timeout: requester 2 sends 1 byte without last, then drops valid; TIMEOUT_TICKS=4. Grant is released exactly on the 4th `baud_x1` after returning to OWN. A waiting requester 3 is granted 1 clk later.
- Tick coincidence: `baud_x1` asserted in the acceptance cycle and in the strobe-rise cycle. Strobe stays high until a later tick. Exactly one buffer write per byte; check the buffer's `w_char_num` increments by 1.
- Reset during HI: assert reset for 1 clk. All outputs are 0 next cycle; a subsequent message from requester 1 transmits correctly.
